// File: rtl/ftdi_tx_controller_if.sv
// FIFO, FU_D bus arbitration and FTDI write-side signals of the transmit controller.
interface ftdi_tx_controller_if;
    logic        bus_req;
    logic        bus_gnt;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic [15:0] fifo_q;
    logic        ftxe_n;
    logic        fwr_n;
    logic        fsiwu_n;
    logic [7:0]  fd_out;
    logic        fd_oe;

    // controller side
    modport master (
        output bus_req, fifo_rdreq, fwr_n, fsiwu_n, fd_out, fd_oe,
        input  bus_gnt, fifo_empty, fifo_q, ftxe_n
    );

    // environment side: FIFO, arbiter and FTDI pins
    modport slave (
        input  bus_req, fifo_rdreq, fwr_n, fsiwu_n, fd_out, fd_oe,
        output bus_gnt, fifo_empty, fifo_q, ftxe_n
    );
endinterface

// File: rtl/ftdi_tx_controller.sv
// FT2232H sync-FIFO transmit controller: drains 16-bit words from the read-back
// FIFO, sends them as two bytes under TXE# flow control, with a one-word
// prefetch so back-to-back words leave at one byte per clock. After the stream
// has been idle for FLUSH_IDLE_CYCLES it pulses SIWU# to flush the FTDI buffer.
module ftdi_tx_controller #(
    parameter int FLUSH_IDLE_CYCLES = 64,
    parameter bit LSB_FIRST         = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    ftdi_tx_controller_if.master        io,
    output logic [31:0]                 bytes_sent,
    output logic                        busy
);
    localparam int CW = $clog2(FLUSH_IDLE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, REQ, FETCH, LOAD, LO, HI} state_t;

    state_t        state;
    logic [15:0]   word_reg;
    logic [15:0]   pf_reg;
    logic          pf_valid;
    logic          pf_pending;   // prefetch read issued last cycle, data on fifo_q now
    logic          sent;
    logic [CW-1:0] idle_cnt;

    logic          accept;
    logic          pf_take;
    logic          pf_avail;
    logic [15:0]   pf_word;

    function automatic logic [7:0] first_byte(input logic [15:0] w);
        return LSB_FIRST ? w[7:0] : w[15:8];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] w);
        return LSB_FIRST ? w[15:8] : w[7:0];
    endfunction

    // The FTDI takes the byte on an edge where both WR# and TXE# are low.
    assign accept   = !io.fwr_n && !io.ftxe_n;
    // Prefetch the next word while the first byte of this one is accepted.
    assign pf_take  = (state == LO) && accept && enable && !io.fifo_empty
                      && !pf_valid && !pf_pending;
    // A pending prefetch can be used directly off fifo_q, which keeps the gap at zero.
    assign pf_avail = pf_valid || pf_pending;
    assign pf_word  = pf_valid ? pf_reg : io.fifo_q;

    // Reads are gated by rst so an in-flight word is never re-read during reset.
    assign io.fifo_rdreq = !rst && ((state == FETCH) || pf_take);
    assign busy          = (state != IDLE);

    // Main FSM; pin outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            io.bus_req <= 1'b0;
            io.fwr_n   <= 1'b1;
            io.fd_oe   <= 1'b0;
            io.fd_out  <= 8'h00;
            word_reg   <= 16'h0000;
            pf_reg     <= 16'h0000;
            pf_valid   <= 1'b0;
            pf_pending <= 1'b0;
        end else begin
            pf_pending <= pf_take;
            if (pf_pending && !(state == HI && accept)) begin
                pf_reg   <= io.fifo_q;
                pf_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (enable && !io.fifo_empty) begin
                        state      <= REQ;
                        io.bus_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (io.bus_gnt) state <= FETCH;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    word_reg  <= io.fifo_q;
                    io.fd_out <= first_byte(io.fifo_q);
                    io.fwr_n  <= 1'b0;
                    io.fd_oe  <= 1'b1;
                    state     <= LO;
                end
                LO: begin
                    if (accept) begin
                        io.fd_out <= second_byte(word_reg);
                        state     <= HI;
                    end
                end
                HI: begin
                    if (accept) begin
                        if (pf_avail) begin
                            word_reg  <= pf_word;
                            pf_valid  <= 1'b0;
                            io.fd_out <= first_byte(pf_word);
                            state     <= LO;
                        end else if (enable && !io.fifo_empty) begin
                            io.fwr_n <= 1'b1;
                            io.fd_oe <= 1'b0;
                            state    <= FETCH;
                        end else begin
                            io.fwr_n   <= 1'b1;
                            io.fd_oe   <= 1'b0;
                            io.bus_req <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte counter, sent-flag and idle counter driving the send-immediate pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            bytes_sent <= 32'h0;
            sent       <= 1'b0;
            idle_cnt   <= '0;
            io.fsiwu_n <= 1'b1;
        end else begin
            bytes_sent <= bytes_sent + 32'(accept);
            io.fsiwu_n <= 1'b1;
            if (accept) sent <= 1'b1;
            if (state == IDLE && io.fifo_empty) begin
                if (idle_cnt == CW'(FLUSH_IDLE_CYCLES)) begin
                    // saturate here until there is something to flush
                    if (sent) begin
                        io.fsiwu_n <= 1'b0;
                        sent       <= 1'b0;
                        idle_cnt   <= '0;
                    end
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end
endmodule
